filtered_ram_swap_control: RTL and testbench



---
 rtl/filtered_ram_swap_control_pkg.sv | 23 ++
 rtl/filtered_ram_swap_control_bank.sv | 56 +++++
 rtl/filtered_ram_swap_control.sv | 124 ++++++++++++
 tb/tb_filtered_ram_swap_control.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/filtered_ram_swap_control_pkg.sv
`default_nettype none
// ============================================================================
// filtered_ram_swap_control_pkg
// Shared widths, bank depth and swap-control state encoding.
// Revision: 1.0
// ============================================================================
package filtered_ram_swap_control_pkg;

    localparam int c_ANGLE_LEN  = 9;
    localparam int c_S_LEN      = 4;
    localparam int c_DATA_LEN   = 16;
    localparam int c_BANK_DEPTH = 2 ** (c_S_LEN - 1);

    // Encoding is {cur_valid, pend_full}
    typedef enum logic [1:0] {
        EMPTY_S          = 2'b00,
        PENDING_S        = 2'b01,
        ACTIVE_S         = 2'b10,
        ACTIVE_PENDING_S = 2'b11
    } frsc_state_t;

endpackage
`default_nettype wire

// File: rtl/filtered_ram_swap_control_bank.sv
`default_nettype none
// ============================================================================
// filtered_ram_bank
// One projection bank: single write port, two registered range-checked reads.
// Revision: 1.0
// ============================================================================
module filtered_ram_bank
    import filtered_ram_swap_control_pkg::*;
#(
    parameter int S_LEN    = c_S_LEN,
    parameter int DATA_LEN = c_DATA_LEN
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_we,
    input  logic [S_LEN-2:0]    i_waddr,
    input  logic [DATA_LEN-1:0] i_wdata,
    input  logic [S_LEN-1:0]    i_raddr0,
    input  logic [S_LEN-1:0]    i_raddr1,
    output logic [DATA_LEN-1:0] o_rdata0,
    output logic [DATA_LEN-1:0] o_rdata1
);

    localparam int DEPTH = 2 ** (S_LEN - 1);

    logic [DATA_LEN-1:0] r_mem [DEPTH];
    logic [DATA_LEN-1:0] r_rd0;
    logic [DATA_LEN-1:0] r_rd1;

    // A signed index is in range exactly when its sign bit is clear
    logic w_ok0;
    logic w_ok1;
    assign w_ok0 = ~i_raddr0[S_LEN-1];
    assign w_ok1 = ~i_raddr1[S_LEN-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd0 <= '0;
            r_rd1 <= '0;
        end else begin
            r_rd0 <= w_ok0 ? r_mem[i_raddr0[S_LEN-2:0]] : '0;
            r_rd1 <= w_ok1 ? r_mem[i_raddr1[S_LEN-2:0]] : '0;
        end
    end

    assign o_rdata0 = r_rd0;
    assign o_rdata1 = r_rd1;

endmodule
`default_nettype wire

// File: rtl/filtered_ram_swap_control.sv
`default_nettype none
// ============================================================================
// filtered_ram_swap_control
// Double-buffered filtered-projection RAM with next-angle swap handshake.
// Revision: 1.0
// ============================================================================
module filtered_ram_swap_control
    import filtered_ram_swap_control_pkg::*;
#(
    parameter int ANGLE_LEN = c_ANGLE_LEN,
    parameter int S_LEN     = c_S_LEN,
    parameter int DATA_LEN  = c_DATA_LEN
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flt_valid,
    output logic                 flt_ready,
    input  logic [ANGLE_LEN-1:0] flt_angle,
    input  logic [S_LEN-2:0]     flt_s,
    input  logic [DATA_LEN-1:0]  flt_val,
    input  logic                 flt_last,
    input  logic                 fr_next_angle,
    output logic                 fr_next_angle_ack,
    output logic                 fr_has_next_angle,
    output logic [ANGLE_LEN-1:0] fr_angle,
    input  logic [S_LEN-1:0]     fr0_s_val,
    input  logic [S_LEN-1:0]     fr1_s_val,
    output logic [DATA_LEN-1:0]  fr0_val,
    output logic [DATA_LEN-1:0]  fr1_val
);

    frsc_state_t          r_state;
    frsc_state_t          w_state_next;
    logic                 r_rd_sel;
    logic                 r_rd_sel_d;
    logic                 r_cur_valid_d;
    logic [ANGLE_LEN-1:0] r_pend_angle;
    logic [ANGLE_LEN-1:0] r_fr_angle;

    logic w_cur_valid;
    logic w_pend_full;
    logic w_accept;
    logic w_accept_last;
    logic w_ack;
    logic w_we0;
    logic w_we1;
    logic [DATA_LEN-1:0] w_b0_rd0, w_b0_rd1, w_b1_rd0, w_b1_rd1;

    assign w_cur_valid   = r_state[1];
    assign w_pend_full   = r_state[0];
    assign flt_ready     = reset_n && !w_pend_full;
    assign w_accept      = flt_valid && flt_ready;
    assign w_accept_last = w_accept && flt_last;
    assign w_ack         = fr_next_angle && w_pend_full;
    assign w_we0         = w_accept && r_rd_sel;
    assign w_we1         = w_accept && !r_rd_sel;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY_S:          if (w_accept_last) w_state_next = PENDING_S;
            PENDING_S:        if (w_ack)         w_state_next = ACTIVE_S;
            ACTIVE_S:         if (w_accept_last) w_state_next = ACTIVE_PENDING_S;
            ACTIVE_PENDING_S: if (w_ack)         w_state_next = ACTIVE_S;
            default:                             w_state_next = EMPTY_S;
        endcase
    end

    // Read-path select and validity are delayed one cycle so a read sampled
    // before a swap edge still returns the bank that was current at sample time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= EMPTY_S;
            r_rd_sel      <= 1'b0;
            r_rd_sel_d    <= 1'b0;
            r_cur_valid_d <= 1'b0;
            r_pend_angle  <= '0;
            r_fr_angle    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_rd_sel_d    <= r_rd_sel;
            r_cur_valid_d <= w_cur_valid;
            if (w_accept_last) begin
                r_pend_angle <= flt_angle;
            end
            if (w_ack) begin
                r_rd_sel   <= !r_rd_sel;
                r_fr_angle <= r_pend_angle;
            end
        end
    end

    filtered_ram_bank #(.S_LEN(S_LEN), .DATA_LEN(DATA_LEN)) u_bank0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_we     (w_we0),
        .i_waddr  (flt_s),
        .i_wdata  (flt_val),
        .i_raddr0 (fr0_s_val),
        .i_raddr1 (fr1_s_val),
        .o_rdata0 (w_b0_rd0),
        .o_rdata1 (w_b0_rd1)
    );

    filtered_ram_bank #(.S_LEN(S_LEN), .DATA_LEN(DATA_LEN)) u_bank1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_we     (w_we1),
        .i_waddr  (flt_s),
        .i_wdata  (flt_val),
        .i_raddr0 (fr0_s_val),
        .i_raddr1 (fr1_s_val),
        .o_rdata0 (w_b1_rd0),
        .o_rdata1 (w_b1_rd1)
    );

    assign fr0_val           = r_cur_valid_d ? (r_rd_sel_d ? w_b1_rd0 : w_b0_rd0) : '0;
    assign fr1_val           = r_cur_valid_d ? (r_rd_sel_d ? w_b1_rd1 : w_b0_rd1) : '0;
    assign fr_next_angle_ack = w_ack;
    assign fr_has_next_angle = w_pend_full;
    assign fr_angle          = r_fr_angle;

endmodule
`default_nettype wire

// File: tb/tb_filtered_ram_swap_control.sv
`default_nettype none
// ============================================================================
// tb_filtered_ram_swap_control
// Directed self-checking bench for the filtered-RAM swap control.
// Revision: 1.0
// ============================================================================
module tb_filtered_ram_swap_control;

    logic        clk;
    logic        reset_n;
    logic        flt_valid;
    logic        flt_ready;
    logic [8:0]  flt_angle;
    logic [2:0]  flt_s;
    logic [15:0] flt_val;
    logic        flt_last;
    logic        fr_next_angle;
    logic        fr_next_angle_ack;
    logic        fr_has_next_angle;
    logic [8:0]  fr_angle;
    logic [3:0]  fr0_s_val;
    logic [3:0]  fr1_s_val;
    logic [15:0] fr0_val;
    logic [15:0] fr1_val;

    int n_vec = 0;
    int n_err = 0;

    filtered_ram_swap_control #(.ANGLE_LEN(9), .S_LEN(4), .DATA_LEN(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .flt_valid         (flt_valid),
        .flt_ready         (flt_ready),
        .flt_angle         (flt_angle),
        .flt_s             (flt_s),
        .flt_val           (flt_val),
        .flt_last          (flt_last),
        .fr_next_angle     (fr_next_angle),
        .fr_next_angle_ack (fr_next_angle_ack),
        .fr_has_next_angle (fr_has_next_angle),
        .fr_angle          (fr_angle),
        .fr0_s_val         (fr0_s_val),
        .fr1_s_val         (fr1_s_val),
        .fr0_val           (fr0_val),
        .fr1_val           (fr1_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int ang, input int s, input int val, input logic last);
        flt_valid = 1'b1;
        flt_angle = 9'(ang);
        flt_s     = 3'(s);
        flt_val   = 16'(val);
        flt_last  = last;
    endtask

    task automatic idle_flt();
        flt_valid = 1'b0;
        flt_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fr_next_angle = 1'b1; fr0_s_val = 4'd3; fr1_s_val = 4'd0;
        idle_flt(); flt_angle = '0; flt_s = '0; flt_val = '0;
        #2;
        n_vec++; if (fr_next_angle_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", fr_next_angle_ack); end
        n_vec++; if (flt_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", flt_ready); end
        n_vec++; if (fr_has_next_angle !== 1'b0) begin n_err++; $display("FAIL rst_has_next: got %b want 0", fr_has_next_angle); end
        n_vec++; if (fr_angle !== 9'd0) begin n_err++; $display("FAIL rst_angle: got %0d want 0", fr_angle); end
        n_vec++; if (fr0_val !== 16'd0 || fr1_val !== 16'd0) begin n_err++; $display("FAIL rst_vals: got %h/%h want 0/0", fr0_val, fr1_val); end
        tick(); tick();
        reset_n = 1'b1; fr_next_angle = 1'b0;
        #1;
        n_vec++; if (flt_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", flt_ready); end
        tick();
        n_vec++; if (fr0_val !== 16'd0) begin n_err++; $display("FAIL read_before_ack: got %h want 0", fr0_val); end
    endtask

    task automatic test_fill_first();
        for (int i = 0; i < 8; i++) begin
            beat(30, i, i + 1, i == 7);
            tick();
            if (i == 6) begin
                n_vec++; if (fr_has_next_angle !== 1'b0) begin n_err++; $display("FAIL fill30_early_has_next: got %b want 0", fr_has_next_angle); end
            end
        end
        idle_flt();
        n_vec++; if (fr_has_next_angle !== 1'b1) begin n_err++; $display("FAIL fill30_has_next: got %b want 1", fr_has_next_angle); end
        n_vec++; if (flt_ready !== 1'b0) begin n_err++; $display("FAIL fill30_ready: got %b want 0", flt_ready); end
        fr0_s_val = 4'd3;
        tick();
        n_vec++; if (fr0_val !== 16'd0) begin n_err++; $display("FAIL pending_read: got %h want 0", fr0_val); end
    endtask

    task automatic test_swap();
        fr_next_angle = 1'b1;
        #1;
        n_vec++; if (fr_next_angle_ack !== 1'b1) begin n_err++; $display("FAIL swap_ack: got %b want 1", fr_next_angle_ack); end
        tick();
        fr_next_angle = 1'b0;
        #1;
        n_vec++; if (fr_angle !== 9'd30) begin n_err++; $display("FAIL swap_angle: got %0d want 30", fr_angle); end
        n_vec++; if (fr_has_next_angle !== 1'b0) begin n_err++; $display("FAIL swap_has_next: got %b want 0", fr_has_next_angle); end
        n_vec++; if (flt_ready !== 1'b1) begin n_err++; $display("FAIL swap_ready: got %b want 1", flt_ready); end
        n_vec++; if (fr_next_angle_ack !== 1'b0) begin n_err++; $display("FAIL swap_ack_drop: got %b want 0", fr_next_angle_ack); end
        fr0_s_val = 4'd3; fr1_s_val = 4'd3;
        tick();
        n_vec++; if (fr0_val !== 16'd4 || fr1_val !== 16'd4) begin n_err++; $display("FAIL read_same_idx: got %0d/%0d want 4/4", fr0_val, fr1_val); end
        fr0_s_val = 4'd0; fr1_s_val = 4'd7;
        tick();
        n_vec++; if (fr0_val !== 16'd1 || fr1_val !== 16'd8) begin n_err++; $display("FAIL read_edges: got %0d/%0d want 1/8", fr0_val, fr1_val); end
        fr0_s_val = 4'hF; fr1_s_val = 4'h8;
        tick();
        n_vec++; if (fr0_val !== 16'd0 || fr1_val !== 16'd0) begin n_err++; $display("FAIL read_out_of_range: got %h/%h want 0/0", fr0_val, fr1_val); end
    endtask

    task automatic test_hold_request();
        fr_next_angle = 1'b1;
        for (int i = 0; i < 8; i++) begin
            beat(60, i, 100 + i, i == 7);
            #1;
            n_vec++; if (fr_next_angle_ack !== 1'b0) begin n_err++; $display("FAIL hold_no_ack beat %0d: got %b want 0", i, fr_next_angle_ack); end
            tick();
        end
        idle_flt();
        #1;
        n_vec++; if (fr_next_angle_ack !== 1'b1) begin n_err++; $display("FAIL hold_ack_next: got %b want 1", fr_next_angle_ack); end
        n_vec++; if (fr_angle !== 9'd30) begin n_err++; $display("FAIL hold_angle_before: got %0d want 30", fr_angle); end
        tick();
        fr_next_angle = 1'b0;
        #1;
        n_vec++; if (fr_angle !== 9'd60) begin n_err++; $display("FAIL hold_angle_after: got %0d want 60", fr_angle); end
        fr0_s_val = 4'd5; fr1_s_val = 4'd7;
        tick();
        n_vec++; if (fr0_val !== 16'd105 || fr1_val !== 16'd107) begin n_err++; $display("FAIL hold_read: got %0d/%0d want 105/107", fr0_val, fr1_val); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            beat(90, i, 200 + i, i == 7);
            fr0_s_val = 4'(i); fr1_s_val = 4'(7 - i);
            tick();
            n_vec++; if (fr0_val !== 16'(100 + i) || fr1_val !== 16'(107 - i)) begin n_err++; $display("FAIL concurrent_read beat %0d: got %0d/%0d want %0d/%0d", i, fr0_val, fr1_val, 100 + i, 107 - i); end
        end
        idle_flt();
        n_vec++; if (fr_has_next_angle !== 1'b1 || fr_angle !== 9'd60) begin n_err++; $display("FAIL fill90_state: got %b/%0d want 1/60", fr_has_next_angle, fr_angle); end
        fr0_s_val = 4'd2; fr1_s_val = 4'd1; fr_next_angle = 1'b1;
        #1;
        n_vec++; if (fr_next_angle_ack !== 1'b1) begin n_err++; $display("FAIL swap90_ack: got %b want 1", fr_next_angle_ack); end
        tick();
        fr_next_angle = 1'b0;
        n_vec++; if (fr0_val !== 16'd102 || fr_angle !== 9'd90) begin n_err++; $display("FAIL straddle_read: got %0d/%0d want 102/90", fr0_val, fr_angle); end
        tick();
        n_vec++; if (fr0_val !== 16'd202 || fr1_val !== 16'd201) begin n_err++; $display("FAIL after_swap_read: got %0d/%0d want 202/201", fr0_val, fr1_val); end
        n_vec++; if (flt_ready !== 1'b1) begin n_err++; $display("FAIL refill_ready: got %b want 1", flt_ready); end
        beat(120, 0, -5, 1'b1);
        tick();
        idle_flt();
        n_vec++; if (fr_has_next_angle !== 1'b1 || fr0_val !== 16'd202) begin n_err++; $display("FAIL refill_state: got %b/%0d want 1/202", fr_has_next_angle, fr0_val); end
        fr_next_angle = 1'b1;
        tick();
        fr_next_angle = 1'b0;
        fr0_s_val = 4'd0; fr1_s_val = 4'd1;
        tick();
        n_vec++; if (fr_angle !== 9'd120) begin n_err++; $display("FAIL swap120_angle: got %0d want 120", fr_angle); end
        n_vec++; if (fr0_val !== 16'hFFFB || fr1_val !== 16'd101) begin n_err++; $display("FAIL swap120_read: got %h/%0d want fffb/101", fr0_val, fr1_val); end
    endtask

    task automatic test_reset_mid();
        beat(150, 0, 33, 1'b1);
        tick();
        idle_flt();
        n_vec++; if (fr_has_next_angle !== 1'b1 || fr0_val !== 16'hFFFB) begin n_err++; $display("FAIL premid_state: got %b/%h want 1/fffb", fr_has_next_angle, fr0_val); end
        #2;
        reset_n = 1'b0; fr_next_angle = 1'b1;
        #1;
        n_vec++; if (fr_angle !== 9'd0 || fr_has_next_angle !== 1'b0) begin n_err++; $display("FAIL midrst_state: got %0d/%b want 0/0", fr_angle, fr_has_next_angle); end
        n_vec++; if (fr0_val !== 16'd0 || fr1_val !== 16'd0) begin n_err++; $display("FAIL midrst_vals: got %h/%h want 0/0", fr0_val, fr1_val); end
        n_vec++; if (flt_ready !== 1'b0 || fr_next_angle_ack !== 1'b0) begin n_err++; $display("FAIL midrst_hs: got %b/%b want 0/0", flt_ready, fr_next_angle_ack); end
        tick();
        reset_n = 1'b1;
        #1;
        n_vec++; if (flt_ready !== 1'b1 || fr_next_angle_ack !== 1'b0) begin n_err++; $display("FAIL midrst_release: got %b/%b want 1/0", flt_ready, fr_next_angle_ack); end
        tick();
        n_vec++; if (fr0_val !== 16'd0 || fr_angle !== 9'd0 || fr_has_next_angle !== 1'b0) begin n_err++; $display("FAIL midrst_empty: got %h/%0d/%b want 0/0/0", fr0_val, fr_angle, fr_has_next_angle); end
        fr_next_angle = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_first();
        test_swap();
        test_hold_request();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
